// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and the
// per-cycle control bundle that drives the pipeline-register enable/clear pins.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StTimeout = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_enable;
    logic ifid_enable;
    logic ifid_clear;
    logic idex_enable;
    logic idex_clear;
    logic exmem_enable;
    logic exmem_clear;
    logic memwb_clear;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CtrlNormal = '{
    pc_enable: 1'b1, ifid_enable: 1'b1, ifid_clear: 1'b0, idex_enable: 1'b1,
    idex_clear: 1'b0, exmem_enable: 1'b1, exmem_clear: 1'b0, memwb_clear: 1'b0
  };

  // Everything up to EX/MEM holds; MEM/WB gets a bubble so the stalled op never writes back twice.
  localparam ctrl_bundle_t CtrlFreeze = '{
    pc_enable: 1'b0, ifid_enable: 1'b0, ifid_clear: 1'b0, idex_enable: 1'b0,
    idex_clear: 1'b0, exmem_enable: 1'b0, exmem_clear: 1'b0, memwb_clear: 1'b1
  };

  localparam ctrl_bundle_t CtrlFlush = '{
    pc_enable: 1'b1, ifid_enable: 1'b1, ifid_clear: 1'b1, idex_enable: 1'b1,
    idex_clear: 1'b1, exmem_enable: 1'b1, exmem_clear: 1'b1, memwb_clear: 1'b0
  };

  localparam ctrl_bundle_t CtrlBubble = '{
    pc_enable: 1'b0, ifid_enable: 1'b0, ifid_clear: 1'b0, idex_enable: 1'b1,
    idex_clear: 1'b1, exmem_enable: 1'b1, exmem_clear: 1'b0, memwb_clear: 1'b0
  };

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the processor datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic [REG_W-1:0] idex_rd;
  logic             idex_memread;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             exmem_redirect;
  logic             mem_ready;
  logic             mem_req;
  logic             pc_enable;
  logic             ifid_enable;
  logic             ifid_clear;
  logic             idex_enable;
  logic             idex_clear;
  logic             exmem_enable;
  logic             exmem_clear;
  logic             memwb_clear;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_memread, exmem_memwrite,
           exmem_redirect, mem_ready,
    input  mem_req, pc_enable, ifid_enable, ifid_clear, idex_enable, idex_clear, exmem_enable,
           exmem_clear, memwb_clear, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_memread, exmem_memwrite,
           exmem_redirect, mem_ready,
    output mem_req, pc_enable, ifid_enable, ifid_clear, idex_enable, idex_clear, exmem_enable,
           exmem_clear, memwb_clear, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline sequencer: load-use bubbles, redirect squashes, memory-wait freeze
// with timeout, plus saturating stall/flush event counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);
  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

  ctrl_state_e      state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d, wait_next;
  ctrl_bundle_t     ctrl;
  logic [REG_W-1:0] ex_rd;
  logic             mem_op, mem_stall, load_use, flush_inc, stall_inc;

  assign ex_rd     = bus.idex_rd;
  assign mem_op    = bus.exmem_memread | bus.exmem_memwrite;
  assign mem_stall = mem_op & ~bus.mem_ready;
  // rs2 is compared even for I-type; an occasional false stall is cheaper than decoding.
  assign load_use  = bus.idex_memread && (ex_rd != '0) &&
                     ((ex_rd == bus.ifid_rs1) || (ex_rd == bus.ifid_rs2));

  always_comb begin
    ctrl      = CtrlNormal;
    state_d   = state_q;
    wait_d    = wait_q;
    wait_next = (state_q == StRun) ? WaitW'(1) : wait_q + WaitW'(1);
    flush_inc = 1'b0;
    if (state_q == StTimeout) begin
      ctrl = CtrlFreeze;
    end else if (mem_stall) begin
      ctrl    = CtrlFreeze;
      wait_d  = wait_next;
      state_d = (wait_next >= WaitW'(WAIT_LIMIT)) ? StTimeout : StMemWait;
    end else begin
      state_d = StRun;
      wait_d  = '0;
      if (bus.exmem_redirect) begin
        ctrl      = CtrlFlush;
        flush_inc = 1'b1;
      end else if (load_use) begin
        ctrl = CtrlBubble;
      end
    end
    // Reset overrides combinationally so the pins are safe before any clock edge.
    if (reset) begin
      ctrl      = CtrlNormal;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = ~ctrl.pc_enable & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.mem_req      = mem_op && (state_q != StTimeout) && !reset;
  assign bus.mem_timeout  = (state_q == StTimeout);
  assign bus.pc_enable    = ctrl.pc_enable;
  assign bus.ifid_enable  = ctrl.ifid_enable;
  assign bus.ifid_clear   = ctrl.ifid_clear;
  assign bus.idex_enable  = ctrl.idex_enable;
  assign bus.idex_clear   = ctrl.idex_clear;
  assign bus.exmem_enable = ctrl.exmem_enable;
  assign bus.exmem_clear  = ctrl.exmem_clear;
  assign bus.memwb_clear  = ctrl.memwb_clear;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (stall_inc),
    .count_o(bus.stall_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (flush_inc),
    .count_o(bus.flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: a cycle-level reference model pushes expected pins per cycle; a monitor
// pops and compares them mid-cycle. Directed scenarios first, then random traffic.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WAIT_LIMIT = 4;
  localparam int          CntMax     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipeline_hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(
    .REG_W     (REG_W),
    .CNT_W     (CNT_W),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ctl order: pc_en ifid_en ifid_clr idex_en idex_clr exmem_en exmem_clr memwb_clr req timeout
  typedef struct {
    logic [9:0] ctl;
    int         stall;
    int         flush;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: consecutive unanswered memory cycles, dead flag, event totals.
  bit m_dead;
  int m_wait;
  int m_stall;
  int m_flush;

  function automatic logic [9:0] actual_ctl();
    return {bus.pc_enable, bus.ifid_enable, bus.ifid_clear, bus.idex_enable, bus.idex_clear,
            bus.exmem_enable, bus.exmem_clear, bus.memwb_clear, bus.mem_req, bus.mem_timeout};
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if (actual_ctl() !== e.ctl) begin
      errors++;
      $display("FAIL %s ctl: got %b want %b", e.tag, actual_ctl(), e.ctl);
    end
    checks++;
    if (bus.stall_count !== CNT_W'(e.stall) || bus.flush_count !== CNT_W'(e.flush)) begin
      errors++;
      $display("FAIL %s counts: got stall=%0d flush=%0d want stall=%0d flush=%0d", e.tag,
               bus.stall_count, bus.flush_count, e.stall, e.flush);
    end
  endtask

  task automatic model_reset();
    m_dead = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input string tag, input bit rst, input int rs1, input int rs2,
                      input int rd, input bit ld, input bit mr, input bit mw, input bit redir,
                      input bit rdy);
    exp_t e;
    bit   pc, ie, ic, de, dc, xe, xc, wc, req, mem_op, hazard;
    @(negedge clk);
    reset              = rst;
    bus.ifid_rs1       = REG_W'(rs1);
    bus.ifid_rs2       = REG_W'(rs2);
    bus.idex_rd        = REG_W'(rd);
    bus.idex_memread   = ld;
    bus.exmem_memread  = mr;
    bus.exmem_memwrite = mw;
    bus.exmem_redirect = redir;
    bus.mem_ready      = rdy;
    mem_op = mr | mw;
    hazard = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    if (rst) model_reset();
    e.tag   = tag;
    e.stall = m_stall;
    e.flush = m_flush;
    // Default: everything flows.
    {pc, ie, ic, de, dc, xe, xc, wc} = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    req = mem_op && !m_dead && !rst;
    if (rst) begin
      // reset values already set
    end else if (m_dead || (mem_op && !rdy)) begin
      {pc, ie, de, xe, wc} = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      if (!m_dead) begin
        m_wait++;
        if (m_wait >= WAIT_LIMIT) m_dead = 1;
      end
    end else begin
      m_wait = 0;
      if (redir) begin
        {ic, dc, xc} = 3'b111;
        if (m_flush < CntMax) m_flush++;
      end else if (hazard) begin
        {pc, ie, dc} = {1'b0, 1'b0, 1'b1};
      end
    end
    e.ctl = {pc, ie, ic, de, dc, xe, xc, wc, req, (e.stall >= 0) && m_dead_prev(tag, rst)};
    if (!rst && !pc && m_stall < CntMax) m_stall++;
    sb_q.push_back(e);
  endtask

  // Timeout pin reflects the dead flag as it stood before this cycle's update.
  bit dead_before;
  function automatic bit m_dead_prev(input string tag, input bit rst);
    return rst ? 1'b0 : dead_before;
  endfunction

  always @(negedge clk) dead_before <= m_dead;

  // Monitor: compares one expected entry per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bus.ifid_rs1 = '0; bus.ifid_rs2 = '0; bus.idex_rd = '0; bus.idex_memread = 0;
    bus.exmem_memread = 0; bus.exmem_memwrite = 0; bus.exmem_redirect = 0; bus.mem_ready = 0;
    model_reset();

    // Load-use on rs1 -> single bubble.
    step("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs1",    0, 5, 7, 5, 1, 0, 0, 0, 0);
    step("lu_after",  0, 1, 2, 3, 0, 0, 0, 0, 0);
    step("lu_rs2",    0, 9, 6, 6, 1, 0, 0, 0, 0);
    // x0 destination never stalls.
    step("lw_x0",     0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Redirect wins over load-use.
    step("redir_lu",  0, 5, 0, 5, 1, 0, 0, 1, 1);
    step("redir_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Store waits three cycles, released on the fourth.
    step("rst2",      1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("sw_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("sw_rel",    0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("sw_after",  0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rdy_noop",  0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Stuck memory -> timeout after WAIT_LIMIT frozen cycles; only reset recovers.
    step("rst3",      1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WAIT_LIMIT + 3; i++) step("to_wait", 0, 3, 3, 3, 1, 1, 0, 1, 0);
    step("to_rdy",    0, 0, 0, 0, 0, 1, 0, 1, 1);
    step("to_rst",    1, 0, 0, 0, 0, 1, 0, 0, 0);
    step("to_post",   0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted mid-wait acts before any clock edge.
    step("aw_0",      0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("aw_1",      0, 0, 0, 0, 0, 1, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    e.tag   = "async_rst";
    e.ctl   = 10'b11_0101_0000;
    e.stall = 0;
    e.flush = 0;
    compare(e);
    step("aw_hold",   1, 0, 0, 0, 0, 1, 0, 0, 0);
    step("aw_run",    0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic, including counter saturation and sporadic resets.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 59) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
